// File: rtl/pipe_hold_ctrl_pkg.sv
// Shared constants and helpers for the pipeline hold controller.
// The STALL_PERF_CNT_EN build option uses sat_inc for its stall counter.
package pipe_hold_ctrl_pkg;

  localparam int          DATA_W    = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_INIT   = 32'h0000_3000;
  localparam logic [31:0] CNT_MAX   = 32'hFFFF_FFFF;

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == CNT_MAX) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_hold_ctrl_pipe_reg.sv
// Width-parameterised pipeline register with an asynchronous active-low reset.
// It holds its value when en is low, and clr forces zero with priority over en.
module pipe_reg #(
  parameter int           W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      q <= RST_VAL;
    else if (clr)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/pipe_hold_ctrl.sv
// Owns the PC, F/D and D/E registers: a stall freezes PC and F/D and sends a NOP bubble into E.
// The optional STALL_PERF_CNT_EN build adds a saturating count of stall cycles on stall_cnt.
module pipe_hold_ctrl
  import pipe_hold_ctrl_pkg::*;
#(
  parameter int            DW       = DATA_W,
  parameter logic [DW-1:0] PC_RESET = PC_INIT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic [DW-1:0] F_NPC,
  input  logic [DW-1:0] F_Instr,
  input  logic [DW-1:0] D_RS_val,
  input  logic [DW-1:0] D_RT_val,
  input  logic [DW-1:0] D_EXT,
  output logic [DW-1:0] F_PC,
  output logic [DW-1:0] D_PC,
  output logic [DW-1:0] D_Instr,
  output logic [DW-1:0] E_PC,
  output logic [DW-1:0] E_Instr,
  output logic [DW-1:0] E_RS_val,
  output logic [DW-1:0] E_RT_val,
  output logic [DW-1:0] E_EXT,
  output logic [31:0]   stall_cnt
);

  logic [2*DW-1:0] fd_q;
  logic [4*DW-1:0] de_q;

  pipe_reg #(.W(DW), .RST_VAL(PC_RESET)) u_pc (
    .clk   (clk),
    .reset (reset),
    .en    (~stall),
    .clr   (1'b0),
    .d     (F_NPC),
    .q     (F_PC)
  );

  pipe_reg #(.W(2*DW), .RST_VAL('0)) u_fd (
    .clk   (clk),
    .reset (reset),
    .en    (~stall),
    .clr   (1'b0),
    .d     ({F_PC, F_Instr}),
    .q     (fd_q)
  );

  assign {D_PC, D_Instr} = fd_q;

  // Clearing this register is the bubble: an all-zero instruction is sll $0,$0,0.
  pipe_reg #(.W(4*DW), .RST_VAL('0)) u_de (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .clr   (stall),
    .d     ({D_Instr, D_RS_val, D_RT_val, D_EXT}),
    .q     (de_q)
  );

  assign {E_Instr, E_RS_val, E_RT_val, E_EXT} = de_q;

  // The bubble keeps the stalled instruction's PC, so E_PC is never cleared.
  pipe_reg #(.W(DW), .RST_VAL('0)) u_de_pc (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .clr   (1'b0),
    .d     (D_PC),
    .q     (E_PC)
  );

`ifdef STALL_PERF_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt_q <= '0;
    else if (stall)
      cnt_q <= sat_inc(cnt_q);
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Scoreboard testbench for pipe_hold_ctrl: a driver pushes the model's expected state, and a monitor pops and compares it.
// The stall_cnt expectation follows STALL_PERF_CNT_EN.
module tb_pipe_hold_ctrl;

`ifdef STALL_PERF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] f_pc, d_pc, d_instr, e_pc, e_instr, e_rs, e_rt, e_ext, cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] F_NPC = '0, F_Instr = '0, D_RS_val = '0, D_RT_val = '0, D_EXT = '0;
  logic [31:0] F_PC, D_PC, D_Instr, E_PC, E_Instr, E_RS_val, E_RT_val, E_EXT, stall_cnt;

  int error_count = 0;
  int check_count = 0;

  exp_t        sb_q[$];
  logic [31:0] m_fpc, m_dpc, m_dinstr, m_epc, m_einstr, m_ers, m_ert, m_eext, m_cnt;
  bit          stream_on = 1'b0;
  logic [31:0] stream_pc;
  int          nonstall_edges;

  pipe_hold_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .F_NPC     (F_NPC),
    .F_Instr   (F_Instr),
    .D_RS_val  (D_RS_val),
    .D_RT_val  (D_RT_val),
    .D_EXT     (D_EXT),
    .F_PC      (F_PC),
    .D_PC      (D_PC),
    .D_Instr   (D_Instr),
    .E_PC      (E_PC),
    .E_Instr   (E_Instr),
    .E_RS_val  (E_RS_val),
    .E_RT_val  (E_RT_val),
    .E_EXT     (E_EXT),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: never zero, so every real instruction is distinguishable from a NOP.
  function automatic logic [31:0] im(input logic [31:0] pc);
    if (pc == 32'h0000_300C) return 32'h8C01_0000;
    return {8'h20, pc[25:2]};
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act !== exp) begin
      error_count++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_fpc = 32'h0000_3000;
    m_dpc = '0; m_dinstr = '0;
    m_epc = '0; m_einstr = '0; m_ers = '0; m_ert = '0; m_eext = '0;
    m_cnt = '0;
  endtask

  // Advances the model by one clock edge using the inputs currently driven, then queues the result.
  task automatic model_push();
    exp_t e;
    m_epc = m_dpc;
    if (stall) begin
      m_einstr = '0; m_ers = '0; m_ert = '0; m_eext = '0;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end else begin
      m_einstr = m_dinstr; m_ers = D_RS_val; m_ert = D_RT_val; m_eext = D_EXT;
      m_dpc = m_fpc; m_dinstr = F_Instr; m_fpc = F_NPC;
      nonstall_edges++;
    end
    e.f_pc = m_fpc; e.d_pc = m_dpc; e.d_instr = m_dinstr; e.e_pc = m_epc;
    e.e_instr = m_einstr; e.e_rs = m_ers; e.e_rt = m_ert; e.e_ext = m_eext;
    e.cnt = CNT_EN ? m_cnt : 32'd0;
    sb_q.push_back(e);
  endtask

  task automatic apply_stimulus(input logic s, input logic [31:0] npc);
    @(negedge clk);
    reset    = 1'b1;
    stall    = s;
    F_NPC    = npc;
    F_Instr  = im(m_fpc);
    D_RS_val = $urandom;
    D_RT_val = $urandom;
    D_EXT    = $urandom;
    model_push();
  endtask

  task automatic wait_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
  endtask

  // The monitor compares the DUT with the oldest queued expectation after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_output("sb_F_PC", F_PC, e.f_pc);
        check_output("sb_D_PC", D_PC, e.d_pc);
        check_output("sb_D_Instr", D_Instr, e.d_instr);
        check_output("sb_E_PC", E_PC, e.e_pc);
        check_output("sb_E_Instr", E_Instr, e.e_instr);
        check_output("sb_E_RS_val", E_RS_val, e.e_rs);
        check_output("sb_E_RT_val", E_RT_val, e.e_rt);
        check_output("sb_E_EXT", E_EXT, e.e_ext);
        check_output("sb_stall_cnt", stall_cnt, e.cnt);
        if (stream_on && E_Instr != 32'h0) begin
          check_output("stream_instr", E_Instr, im(stream_pc));
          check_output("stream_pc", E_PC, stream_pc);
          stream_pc = stream_pc + 32'd4;
        end
      end
    end
  end

  initial begin
    logic [31:0] d_hold, cnt_base;
    nonstall_edges = 0;

    // Reset state.
    do_reset();
    check_output("rst_F_PC", F_PC, 32'h0000_3000);
    check_output("rst_D_Instr", D_Instr, 32'h0);
    check_output("rst_E_Instr", E_Instr, 32'h0);
    check_output("rst_stall_cnt", stall_cnt, 32'h0);

    // Three sequential fetches.
    repeat (3) apply_stimulus(1'b0, m_fpc + 32'd4);
    wait_edge();
    check_output("seq_F_PC", F_PC, 32'h0000_300C);
    check_output("seq_D_PC", D_PC, 32'h0000_3008);
    check_output("seq_E_PC", E_PC, 32'h0000_3004);

    // A single-cycle stall on a lw sitting in D.
    apply_stimulus(1'b0, m_fpc + 32'd4);
    wait_edge();
    check_output("lw_in_D", D_Instr, 32'h8C01_0000);
    apply_stimulus(1'b1, m_fpc + 32'd4);
    wait_edge();
    check_output("stall_D_Instr", D_Instr, 32'h8C01_0000);
    check_output("stall_F_PC", F_PC, 32'h0000_3010);
    check_output("stall_E_Instr", E_Instr, 32'h0);
    check_output("stall_E_PC", E_PC, 32'h0000_300C);
    apply_stimulus(1'b0, m_fpc + 32'd4);
    wait_edge();
    check_output("release_E_Instr", E_Instr, 32'h8C01_0000);
    check_output("release_E_PC", E_PC, 32'h0000_300C);

    // Three consecutive stalls.
    d_hold   = m_dpc;
    cnt_base = m_cnt;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, m_fpc + 32'd4);
      wait_edge();
      check_output("run_D_PC", D_PC, d_hold);
      check_output("run_E_Instr", E_Instr, 32'h0);
    end
    check_output("run_stall_cnt", stall_cnt, CNT_EN ? cnt_base + 32'd3 : 32'd0);

    // Reset dropped mid-stall between edges, then released before the next edge.
    @(negedge clk);
    stall = 1'b1;
    #1 reset = 1'b0;
    model_reset();
    #1;
    check_output("midrst_F_PC", F_PC, 32'h0000_3000);
    check_output("midrst_D_PC", D_PC, 32'h0);
    check_output("midrst_D_Instr", D_Instr, 32'h0);
    check_output("midrst_E_PC", E_PC, 32'h0);
    check_output("midrst_E_Instr", E_Instr, 32'h0);
    check_output("midrst_stall_cnt", stall_cnt, 32'h0);
    #1 reset = 1'b1;
    stall   = 1'b0;
    F_NPC   = 32'h0000_3004;
    F_Instr = im(32'h0000_3000);
    model_push();
    wait_edge();
    check_output("postrst_D_PC", D_PC, 32'h0000_3000);
    check_output("postrst_F_PC", F_PC, 32'h0000_3004);

    // Random stall pattern on a sequential stream: the E stream must be exactly the fetched words.
    do_reset();
    stream_pc      = 32'h0000_3000;
    nonstall_edges = 0;
    stream_on      = 1'b1;
    for (int i = 0; i < 10000; i++)
      apply_stimulus(($urandom % 4) == 0, m_fpc + 32'd4);
    wait_edge();
    stream_on = 1'b0;
    check_output("stream_count", stream_pc, 32'h0000_3000 + 32'(4 * (nonstall_edges - 1)));

    // Random next-PC values, including wrap-around targets.
    for (int i = 0; i < 300; i++)
      apply_stimulus(($urandom % 3) == 0, (i % 10 == 0) ? 32'hFFFF_FFFC + 32'(i % 3) * 4 : $urandom);
    wait_edge();

    check_output("queue_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
